// File: rtl/csr_row_sequencer.sv
// CSR row sequencer: walks row_ptr, then value/column RAMs, and issues one
// token per nonzero (first/last flagged) or one empty-row token per empty row.
module csr_row_sequencer #(
  parameter int ROW_AW = 10,
  parameter int NNZ_AW = 14,
  parameter int VEC_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ROW_AW-1:0] i_num_rows,
  output logic              o_busy,
  output logic              o_done,
  output logic [ROW_AW-1:0] o_rp_addr,
  input  logic [31:0]       i_rp_data,
  output logic [NNZ_AW-1:0] o_nz_addr,
  input  logic [31:0]       i_nz_col,
  output logic              o_issue_valid,
  input  logic              i_issue_ready,
  output logic              o_issue_first,
  output logic              o_issue_last,
  output logic              o_issue_empty,
  output logic [ROW_AW-1:0] o_issue_row,
  output logic [NNZ_AW-1:0] o_issue_nz,
  output logic [VEC_AW-1:0] o_vec_addr,
  output logic [NNZ_AW:0]   o_nnz_count,
  output logic              o_err_ptr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_P0,
    S_C_P0,
    S_W_PN,
    S_EVAL,
    S_W_NZ,
    S_C_NZ,
    S_ISSUE,
    S_FIN
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [ROW_AW-1:0] r_rp_addr;
  logic [NNZ_AW-1:0] r_nz_addr;
  logic              r_issue_valid;
  logic              r_issue_first;
  logic              r_issue_last;
  logic              r_issue_empty;
  logic [ROW_AW-1:0] r_issue_row;
  logic [NNZ_AW-1:0] r_issue_nz;
  logic [VEC_AW-1:0] r_vec_addr;
  logic [NNZ_AW:0]   r_nnz_count;
  logic              r_err_ptr;

  logic [ROW_AW-1:0] r_num_rows;
  logic [ROW_AW-1:0] r_row;
  logic [NNZ_AW-1:0] r_ptr_lo;
  logic [NNZ_AW-1:0] r_ptr_hi;
  logic [NNZ_AW-1:0] r_k;

  logic [NNZ_AW-1:0] w_hi;
  logic [ROW_AW-1:0] w_row_inc;
  logic [ROW_AW-1:0] w_row_inc2;
  logic [NNZ_AW-1:0] w_k_inc;
  logic              w_last_row;
  logic [NNZ_AW:0]   w_nnz_inc;
  logic              w_unused_bits;

  // Row pointers only carry NNZ_AW meaningful bits; column index only VEC_AW.
  assign w_hi          = i_rp_data[NNZ_AW-1:0];
  assign w_unused_bits = ^{i_rp_data[31:NNZ_AW], i_nz_col[31:VEC_AW]};

  assign w_row_inc  = r_row + ROW_AW'(1);
  assign w_row_inc2 = r_row + ROW_AW'(2);
  assign w_k_inc    = r_k + NNZ_AW'(1);
  assign w_last_row = (r_row == (r_num_rows - ROW_AW'(1)));
  // Nonzero counter sticks at all-ones instead of wrapping.
  assign w_nnz_inc  = (r_nnz_count == '1) ? r_nnz_count : (r_nnz_count + (NNZ_AW+1)'(1));

  // Sequencer FSM: RAM fetches take LD -> wait -> capture, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rp_addr     <= '0;
      r_nz_addr     <= '0;
      r_issue_valid <= 1'b0;
      r_issue_first <= 1'b0;
      r_issue_last  <= 1'b0;
      r_issue_empty <= 1'b0;
      r_issue_row   <= '0;
      r_issue_nz    <= '0;
      r_vec_addr    <= '0;
      r_nnz_count   <= '0;
      r_err_ptr     <= 1'b0;
      r_num_rows    <= '0;
      r_row         <= '0;
      r_ptr_lo      <= '0;
      r_ptr_hi      <= '0;
      r_k           <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy      <= 1'b1;
            r_num_rows  <= i_num_rows;
            r_nnz_count <= '0;
            r_row       <= '0;
            if (i_num_rows == '0) begin
              r_state <= S_FIN;
            end else begin
              r_rp_addr <= '0;
              r_state   <= S_W_P0;
            end
          end
        end
        S_W_P0: r_state <= S_C_P0;
        S_C_P0: begin
          // row_ptr[0] is the only pointer read as a low bound in a pass
          r_ptr_lo  <= w_hi;
          r_rp_addr <= w_row_inc;
          r_state   <= S_W_PN;
        end
        S_W_PN: r_state <= S_EVAL;
        S_EVAL: begin
          r_ptr_hi <= w_hi;
          if (w_hi < r_ptr_lo) begin
            r_err_ptr <= 1'b1;
          end
          if (w_hi <= r_ptr_lo) begin
            // empty row (or decreasing pointer): one token so a zero is written
            r_issue_valid <= 1'b1;
            r_issue_first <= 1'b1;
            r_issue_last  <= 1'b1;
            r_issue_empty <= 1'b1;
            r_issue_row   <= r_row;
            r_issue_nz    <= r_ptr_lo;
            r_vec_addr    <= '0;
            r_state       <= S_ISSUE;
          end else begin
            r_nz_addr <= r_ptr_lo;
            r_k       <= r_ptr_lo;
            r_state   <= S_W_NZ;
          end
        end
        S_W_NZ: r_state <= S_C_NZ;
        S_C_NZ: begin
          r_issue_valid <= 1'b1;
          r_issue_first <= (r_k == r_ptr_lo);
          r_issue_last  <= (w_k_inc == r_ptr_hi);
          r_issue_empty <= 1'b0;
          r_issue_row   <= r_row;
          r_issue_nz    <= r_k;
          r_vec_addr    <= i_nz_col[VEC_AW-1:0];
          r_state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (i_issue_ready) begin
            r_issue_valid <= 1'b0;
            if (!r_issue_last) begin
              r_nnz_count <= w_nnz_inc;
              r_k         <= w_k_inc;
              r_nz_addr   <= w_k_inc;
              r_state     <= S_W_NZ;
            end else begin
              if (!r_issue_empty) begin
                r_nnz_count <= w_nnz_inc;
              end
              // next row's low bound is this row's high bound, even if it went backwards
              r_ptr_lo <= r_ptr_hi;
              r_row    <= w_row_inc;
              if (w_last_row) begin
                r_state <= S_FIN;
              end else begin
                r_rp_addr <= w_row_inc2;
                r_state   <= S_W_PN;
              end
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rp_addr     = r_rp_addr;
  assign o_nz_addr     = r_nz_addr;
  assign o_issue_valid = r_issue_valid;
  assign o_issue_first = r_issue_first;
  assign o_issue_last  = r_issue_last;
  assign o_issue_empty = r_issue_empty;
  assign o_issue_row   = r_issue_row;
  assign o_issue_nz    = r_issue_nz;
  assign o_vec_addr    = r_vec_addr;
  assign o_nnz_count   = r_nnz_count;
  assign o_err_ptr     = r_err_ptr;

endmodule

// File: tb/tb_csr_row_sequencer.sv
// Directed bench for csr_row_sequencer with small behavioural row_ptr/column RAMs.
module tb_csr_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [9:0]  i_num_rows;
  logic        o_busy;
  logic        o_done;
  logic [9:0]  o_rp_addr;
  logic [31:0] i_rp_data;
  logic [13:0] o_nz_addr;
  logic [31:0] i_nz_col;
  logic        o_issue_valid;
  logic        i_issue_ready;
  logic        o_issue_first;
  logic        o_issue_last;
  logic        o_issue_empty;
  logic [9:0]  o_issue_row;
  logic [13:0] o_issue_nz;
  logic [9:0]  o_vec_addr;
  logic [14:0] o_nnz_count;
  logic        o_err_ptr;

  logic [31:0] rp_mem  [0:15];
  logic [31:0] col_mem [0:15];

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int d0;
  int h0;

  csr_row_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_num_rows   (i_num_rows),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rp_addr    (o_rp_addr),
    .i_rp_data    (i_rp_data),
    .o_nz_addr    (o_nz_addr),
    .i_nz_col     (i_nz_col),
    .o_issue_valid(o_issue_valid),
    .i_issue_ready(i_issue_ready),
    .o_issue_first(o_issue_first),
    .o_issue_last (o_issue_last),
    .o_issue_empty(o_issue_empty),
    .o_issue_row  (o_issue_row),
    .o_issue_nz   (o_issue_nz),
    .o_vec_addr   (o_vec_addr),
    .o_nnz_count  (o_nnz_count),
    .o_err_ptr    (o_err_ptr)
  );

  always #5 clk = ~clk;

  // synchronous RAMs, one cycle of read latency
  always @(posedge clk) begin
    i_rp_data <= rp_mem[o_rp_addr[3:0]];
    i_nz_col  <= col_mem[o_nz_addr[3:0]];
  end

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_issue_valid && i_issue_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_rp(input int a, input int b, input int c, input int d);
    // upper bits are junk that the sequencer must ignore
    rp_mem[0] = 32'hA5A4_0000 | 32'(a);
    rp_mem[1] = 32'hA5A4_0000 | 32'(b);
    rp_mem[2] = 32'hA5A4_0000 | 32'(c);
    rp_mem[3] = 32'hA5A4_0000 | 32'(d);
  endtask

  task automatic do_start(input logic [9:0] n);
    i_start    = 1'b1;
    i_num_rows = n;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  task automatic get_token(input string tag, input logic [9:0] row, input logic [13:0] nz,
                           input logic f, input logic l, input logic e, input logic [9:0] vec);
    int n;
    n = 0;
    while (!(o_issue_valid && i_issue_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 96'(o_issue_valid), 96'd1);
    check(tag, 96'({o_issue_row, o_issue_nz, o_issue_first, o_issue_last, o_issue_empty, o_vec_addr}),
          96'({row, nz, f, l, e, vec}));
    $display("token %s row=%0d nz=%0d first=%0d last=%0d empty=%0d vec=%0d", tag,
             o_issue_row, o_issue_nz, o_issue_first, o_issue_last, o_issue_empty, o_vec_addr);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!o_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 96'(o_done), 96'd1);
  endtask

  // matrix row_ptr={0,2,2,5}, all tokens accepted immediately
  task automatic run_s1(input string p);
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(10'd3);
    check({p, "_busy"}, 96'(o_busy), 96'd1);
    get_token({p, "_t0"}, 10'd0, 14'd0, 1'b1, 1'b0, 1'b0, 10'd5);
    get_token({p, "_t1"}, 10'd0, 14'd1, 1'b0, 1'b1, 1'b0, 10'd42);
    get_token({p, "_t2"}, 10'd1, 14'd2, 1'b1, 1'b1, 1'b1, 10'd0);
    get_token({p, "_t3"}, 10'd2, 14'd2, 1'b1, 1'b0, 1'b0, 10'd79);
    get_token({p, "_t4"}, 10'd2, 14'd3, 1'b0, 1'b0, 1'b0, 10'd116);
    get_token({p, "_t5"}, 10'd2, 14'd4, 1'b0, 1'b1, 1'b0, 10'd153);
    wait_done(p);
    check({p, "_nnz_err"}, 96'({o_nnz_count, o_err_ptr}), 96'({15'd5, 1'b0}));
    repeat (3) @(negedge clk);
    check({p, "_done_cnt"}, 96'(done_cnt - d0), 96'd1);
    check({p, "_hs_cnt"}, 96'(hs_cnt - h0), 96'd6);
    check({p, "_idle_busy"}, 96'(o_busy), 96'd0);
  endtask

  initial begin
    int n;
    int busy_cycles;
    int done_at;

    for (int i = 0; i < 16; i++) begin
      rp_mem[i]  = 32'd0;
      col_mem[i] = 32'hFFFF_F000 + 32'(i * 37 + 5);
    end
    rst           = 1'b0;
    i_start       = 1'b0;
    i_num_rows    = 10'd0;
    i_issue_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outs",
          96'({o_busy, o_done, o_rp_addr, o_nz_addr, o_issue_valid, o_issue_first, o_issue_last,
               o_issue_empty, o_issue_row, o_issue_nz, o_vec_addr, o_nnz_count, o_err_ptr}), 96'd0);
    rst = 1'b1;
    @(negedge clk);

    // scenario 1: basic pass
    load_rp(0, 2, 2, 5);
    run_s1("s1");

    // scenario 2: back-pressure on token (2,3)
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(10'd3);
    get_token("s2_t0", 10'd0, 14'd0, 1'b1, 1'b0, 1'b0, 10'd5);
    get_token("s2_t1", 10'd0, 14'd1, 1'b0, 1'b1, 1'b0, 10'd42);
    get_token("s2_t2", 10'd1, 14'd2, 1'b1, 1'b1, 1'b1, 10'd0);
    get_token("s2_t3", 10'd2, 14'd2, 1'b1, 1'b0, 1'b0, 10'd79);
    i_issue_ready = 1'b0;
    n = 0;
    while (!o_issue_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("s2_stall",
            96'({o_issue_valid, o_issue_row, o_issue_nz, o_issue_first, o_issue_last, o_issue_empty, o_vec_addr}),
            96'({1'b1, 10'd2, 14'd3, 1'b0, 1'b0, 1'b0, 10'd116}));
      if (c < 4) @(negedge clk);
    end
    i_issue_ready = 1'b1;
    get_token("s2_t4", 10'd2, 14'd3, 1'b0, 1'b0, 1'b0, 10'd116);
    get_token("s2_t5", 10'd2, 14'd4, 1'b0, 1'b1, 1'b0, 10'd153);
    wait_done("s2");
    check("s2_nnz", 96'(o_nnz_count), 96'd5);
    repeat (3) @(negedge clk);
    check("s2_done_cnt", 96'(done_cnt - d0), 96'd1);
    check("s2_hs_cnt", 96'(hs_cnt - h0), 96'd6);

    // scenario 3: zero rows, addresses left where the last pass put them
    d0 = done_cnt;
    busy_cycles = 0;
    done_at = 0;
    do_start(10'd0);
    for (int c = 1; c <= 4; c++) begin
      if (o_busy) busy_cycles++;
      if (o_done && done_at == 0) done_at = c;
      check("s3_quiet", 96'({o_issue_valid, o_rp_addr, o_nz_addr}), 96'({1'b0, 10'd3, 14'd4}));
      @(negedge clk);
    end
    check("s3_busy_le2", 96'(busy_cycles >= 1 && busy_cycles <= 2), 96'd1);
    check("s3_done_in3", 96'(done_at >= 1 && done_at <= 3), 96'd1);
    check("s3_done_cnt", 96'(done_cnt - d0), 96'd1);
    check("s3_nnz", 96'(o_nnz_count), 96'd0);
    $display("zero-row pass busy_cycles=%0d done_cycle=%0d", busy_cycles, done_at);

    // scenario 4: decreasing row pointer row_ptr={0,3,1,2}
    load_rp(0, 3, 1, 2);
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(10'd3);
    get_token("s4_t0", 10'd0, 14'd0, 1'b1, 1'b0, 1'b0, 10'd5);
    get_token("s4_t1", 10'd0, 14'd1, 1'b0, 1'b0, 1'b0, 10'd42);
    get_token("s4_t2", 10'd0, 14'd2, 1'b0, 1'b1, 1'b0, 10'd79);
    check("s4_err_pre", 96'(o_err_ptr), 96'd0);
    get_token("s4_t3", 10'd1, 14'd3, 1'b1, 1'b1, 1'b1, 10'd0);
    check("s4_err", 96'(o_err_ptr), 96'd1);
    get_token("s4_t4", 10'd2, 14'd1, 1'b1, 1'b1, 1'b0, 10'd42);
    wait_done("s4");
    check("s4_nnz", 96'(o_nnz_count), 96'd4);
    repeat (3) @(negedge clk);
    check("s4_done_cnt", 96'(done_cnt - d0), 96'd1);
    check("s4_hs_cnt", 96'(hs_cnt - h0), 96'd5);

    // scenario 5: reset while row 2 token is waiting
    load_rp(0, 2, 2, 5);
    do_start(10'd3);
    get_token("s5_t0", 10'd0, 14'd0, 1'b1, 1'b0, 1'b0, 10'd5);
    get_token("s5_t1", 10'd0, 14'd1, 1'b0, 1'b1, 1'b0, 10'd42);
    get_token("s5_t2", 10'd1, 14'd2, 1'b1, 1'b1, 1'b1, 10'd0);
    i_issue_ready = 1'b0;
    n = 0;
    while (!o_issue_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("s5_pending", 96'({o_issue_valid, o_issue_row, o_issue_nz}), 96'({1'b1, 10'd2, 14'd2}));
    d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("s5_rst_outs",
          96'({o_busy, o_done, o_rp_addr, o_nz_addr, o_issue_valid, o_issue_first, o_issue_last,
               o_issue_empty, o_issue_row, o_issue_nz, o_vec_addr, o_nnz_count, o_err_ptr}), 96'd0);
    repeat (6) @(negedge clk);
    check("s5_no_done", 96'({o_busy, 32'(done_cnt - d0)}), 96'd0);
    i_issue_ready = 1'b1;
    run_s1("s5r");

    // scenario 6: start while busy and in FIN ignored; start right after done accepted
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(10'd3);
    get_token("s6_t0", 10'd0, 14'd0, 1'b1, 1'b0, 1'b0, 10'd5);
    do_start(10'd1);
    get_token("s6_t1", 10'd0, 14'd1, 1'b0, 1'b1, 1'b0, 10'd42);
    get_token("s6_t2", 10'd1, 14'd2, 1'b1, 1'b1, 1'b1, 10'd0);
    do_start(10'd0);
    get_token("s6_t3", 10'd2, 14'd2, 1'b1, 1'b0, 1'b0, 10'd79);
    get_token("s6_t4", 10'd2, 14'd3, 1'b0, 1'b0, 1'b0, 10'd116);
    get_token("s6_t5", 10'd2, 14'd4, 1'b0, 1'b1, 1'b0, 10'd153);
    check("s6_fin_busy", 96'({o_busy, o_done}), 96'({1'b1, 1'b0}));
    do_start(10'd3);
    check("s6_done_cycle", 96'({o_busy, o_done}), 96'({1'b0, 1'b1}));
    @(negedge clk);
    check("s6_fin_start_ign", 96'({o_busy, o_done}), 96'd0);
    repeat (3) @(negedge clk);
    check("s6_busy_idle", 96'(o_busy), 96'd0);
    check("s6_done_cnt", 96'(done_cnt - d0), 96'd1);
    check("s6_hs_cnt", 96'(hs_cnt - h0), 96'd6);

    // second pass, then start in the done cycle
    d0 = done_cnt;
    do_start(10'd3);
    get_token("s6b_t0", 10'd0, 14'd0, 1'b1, 1'b0, 1'b0, 10'd5);
    get_token("s6b_t1", 10'd0, 14'd1, 1'b0, 1'b1, 1'b0, 10'd42);
    get_token("s6b_t2", 10'd1, 14'd2, 1'b1, 1'b1, 1'b1, 10'd0);
    get_token("s6b_t3", 10'd2, 14'd2, 1'b1, 1'b0, 1'b0, 10'd79);
    get_token("s6b_t4", 10'd2, 14'd3, 1'b0, 1'b0, 1'b0, 10'd116);
    get_token("s6b_t5", 10'd2, 14'd4, 1'b0, 1'b1, 1'b0, 10'd153);
    @(negedge clk);
    check("s6b_done", 96'({o_busy, o_done}), 96'({1'b0, 1'b1}));
    do_start(10'd0);
    check("s6b_restart_busy", 96'(o_busy), 96'd1);
    wait_done("s6b");
    repeat (3) @(negedge clk);
    check("s6b_done_cnt", 96'(done_cnt - d0), 96'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
